multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- FSM controller that sequences a shared-ALU, shared-memory RISC-V datapath over multiple cycles per instruction.
- It is the multi-cycle counterpart of the single-cycle Controller.
- Decodes opcode/func3/func7 from the instruction register and the zero/sign ALU flags.
- Drives the PC, IR, memory, register-file, mux-select and ALU controls state by state.
- Stalls on a memory-ready handshake.

Parameters:
TRAP_ON_ILLEGAL, 1, 1: an illegal instruction parks the FSM in ILLEGAL until reset; 0: it is treated as a NOP and the FSM returns to FETCH.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
opcode  input  7  IR[6:0], valid from DECODE onward
func3  input  3  IR[14:12]
func7  input  7  IR[31:25]
zero  input  1  ALU result == 0
sign  input  1  ALU result MSB
mem_ready  input  1  memory has completed the current access this cycle
PCWrite  output  1  load PC from the result bus
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  output  1  memory write strobe
IRWrite  output  1  latch IR and OldPC
RegWrite  output  1  register-file write enable
ResultSrc  output  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALU result
ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register, 11 = zero
ALUSrcB  output  2  ALU B select: 00 = rs2 register, 01 = immediate, 10 = constant 4
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor
ImmSrc  output  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
state  output  4  current state (debug)
trap  output  1  high while in ILLEGAL

Behaviour:
- rst low forces state=FETCH immediately (asynchronously), including mid-instruction.
- Outputs are Moore decodes of state. Exception: PCWrite in BRANCH also depends on the flags.
- All strobes are 0 in any state that does not list them. Unlisted selects are 00 and ALUControl is add.
- During reset, the FETCH decode is visible but no state advance occurs.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JUMP=10, JALR=11, LUI=12, ILLEGAL=15.
- Codes 13 and 14 are unreachable; if ever entered, the next state is FETCH.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stay in FETCH while mem_ready=0; otherwise go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add. ImmSrc=J if opcode=jal, else B. This precomputes the jump/branch target into ALUOut. Next state by opcode:
  - 0000011 (lw) or 0100011 (sw) -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JUMP
  - 1100111 -> JALR
  - 0110111 -> LUI
  - any other opcode -> ILLEGAL
- Illegal sub-encodings are also caught in DECODE and go to ILLEGAL:
  - R-type func3 not in {000, 111, 110, 010, 100}
  - I-type func3 outside that same set
  - branch func3 not in {000, 001, 100, 101}
  - R-type func7 other than 0000000, or 0100000 with func3=000
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. ImmSrc=I for lw, S for sw. Next state MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: AdrSrc=1. Wait while mem_ready=0, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, held until mem_ready=1. Next state FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00. ALU decode: func3 000 -> add, or sub when func7[5]=1; 111 -> and; 110 -> or; 010 -> slt; 100 -> xor. Next state ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=I. Same func3 decode as EXECR, always add for 000, func7 ignored. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite is:
  - beq: zero
  - bne: !zero
  - blt: sign
  - bge: !sign
  - Next state FETCH.
- JUMP: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. The PC takes the target from ALUOut while OldPC+4 is computed. Next state ALUWB, which writes rd=OldPC+4.
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, add (rs1+imm into ALUOut). Next state JUMP.
- LUI: ALUSrcA=11, ALUSrcB=01, ImmSrc=U, add. Next state ALUWB.
- ILLEGAL: trap=1, no strobes. Stays in ILLEGAL if TRAP_ON_ILLEGAL=1, else goes to FETCH.
- Latency with mem_ready held high:
  - branch: 3 cycles
  - R-type, I-type, sw, jal, lui: 4 cycles
  - lw, jalr: 5 cycles
  - each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- mem_ready is ignored in every state other than FETCH, MEMREAD and MEMWRITE.

Test Plan:
- Reset, then `add` (0110011, func3=000, func7=0), mem_ready=1 -> states 0,1,6,8,0. ALUControl=000 in EXECR; RegWrite=1 only in ALUWB. Repeat with func7=0100000 -> ALUControl=001.
- lw with mem_ready=0 for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0. AdrSrc=1 throughout MEMREAD; MEMWB gives ResultSrc=01, RegWrite=1.
- sw with mem_ready low for 1 cycle in MEMWRITE -> MemWrite=1 for exactly 2 cycles, then FETCH. IRWrite/PCWrite=0 while FETCH is stalled.
- Branches in BRANCH state:
  - beq, zero=1 -> PCWrite=1; zero=0 -> PCWrite=0.
  - bge, sign=1 -> PCWrite=0.
  - branch func3=010 -> ILLEGAL with trap=1, held 10 cycles (TRAP_ON_ILLEGAL=1).
- jalr -> states 0,1,11,10,8. ImmSrc=I in JALR; PCWrite=1 in JUMP; RegWrite=1 with ResultSrc=00 in ALUWB.
- Assert rst low during MEMWRITE with MemWrite=1 -> state=0 and MemWrite=0 before the next clock edge. On release, FETCH resumes.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_controller: control FSM for a multi-cycle RISC-V datapath that  |
// | shares one ALU and one memory across all steps of an instruction.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multicycle_controller #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       sign,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic [3:0] state,
  output logic       trap
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_ILLEGAL  = 4'd15
  } state_t;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_lui    = 7'b0110111;

  localparam logic [2:0] c_alu_add = 3'b000;
  localparam logic [2:0] c_alu_sub = 3'b001;
  localparam logic [2:0] c_alu_and = 3'b010;
  localparam logic [2:0] c_alu_or  = 3'b011;
  localparam logic [2:0] c_alu_slt = 3'b100;
  localparam logic [2:0] c_alu_xor = 3'b101;

  localparam logic [2:0] c_imm_i = 3'b000;
  localparam logic [2:0] c_imm_s = 3'b001;
  localparam logic [2:0] c_imm_b = 3'b010;
  localparam logic [2:0] c_imm_j = 3'b011;
  localparam logic [2:0] c_imm_u = 3'b100;

  state_t r_state;
  state_t w_next;
  logic   w_f3_alu_ok;
  logic   w_f3_br_ok;
  logic   w_f7_ok;

  function automatic logic [2:0] alu_decode(input logic [2:0] f3);
    case (f3)
      3'b111:  return c_alu_and;
      3'b110:  return c_alu_or;
      3'b010:  return c_alu_slt;
      3'b100:  return c_alu_xor;
      default: return c_alu_add;
    endcase
  endfunction

  assign w_f3_alu_ok = (func3 == 3'b000) || (func3 == 3'b111) || (func3 == 3'b110) ||
                       (func3 == 3'b010) || (func3 == 3'b100);
  assign w_f3_br_ok  = (func3 == 3'b000) || (func3 == 3'b001) ||
                       (func3 == 3'b100) || (func3 == 3'b101);
  assign w_f7_ok     = (func7 == 7'b0000000) || ((func7 == 7'b0100000) && (func3 == 3'b000));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = S_FETCH;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = c_alu_add;
    ImmSrc     = c_imm_i;
    trap       = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        w_next    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALUOut = OldPC + imm gives the branch/jal target ahead of time
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (opcode == c_op_jal) ? c_imm_j : c_imm_b;
        case (opcode)
          c_op_load, c_op_store: w_next = S_MEMADR;
          c_op_rtype:  w_next = (w_f3_alu_ok && w_f7_ok) ? S_EXECR : S_ILLEGAL;
          c_op_itype:  w_next = w_f3_alu_ok ? S_EXECI : S_ILLEGAL;
          c_op_branch: w_next = w_f3_br_ok ? S_BRANCH : S_ILLEGAL;
          c_op_jal:    w_next = S_JUMP;
          c_op_jalr:   w_next = S_JALR;
          c_op_lui:    w_next = S_LUI;
          default:     w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (opcode == c_op_load) ? c_imm_i : c_imm_s;
        w_next  = (opcode == c_op_load) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        w_next   = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = ((func3 == 3'b000) && func7[5]) ? c_alu_sub : alu_decode(func3);
        w_next     = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_decode(func3);
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = c_alu_sub;
        case (func3)
          3'b000:  PCWrite = zero;
          3'b001:  PCWrite = !zero;
          3'b100:  PCWrite = sign;
          3'b101:  PCWrite = !sign;
          default: PCWrite = 1'b0;
        endcase
      end
      S_JUMP: begin
        // PC <= ALUOut (target) while the ALU forms the link value OldPC + 4
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        w_next  = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_next  = S_JUMP;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        ImmSrc  = c_imm_u;
        w_next  = S_ALUWB;
      end
      S_ILLEGAL: begin
        trap   = 1'b1;
        w_next = TRAP_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign state = r_state;

endmodule
`default_nettype wire
